icache_responder: RTL and testbench
===================================

ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 Parameter IC_INDEX_WIDTH, default 6, meaning log2 of entry count (64 direct-mapped entries, halfword-indexed).
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  global enable; low freezes all state, outputs hold.
REQ-005 flush_in  input  1  pipeline flush; abandons current fetch request.
REQ-006 fetch_enable_in  input  1  fetcher requests instruction at pc_in this cycle.
REQ-007 pc_in  input  32  fetch address, halfword-aligned (bit 0 ignored).
REQ-008 ic_hit  output  1  combinational: instruction at pc_in available this cycle.
REQ-009 ic_miss_ready  output  1  registered one-cycle pulse: miss fill complete, ic_instr valid.
REQ-010 ic_instr  output  32  instruction word starting at requested pc (low 16 bits only meaningful for compressed).
REQ-011 mem_req  output  1  registered fetch request to memory controller, level until accepted.
REQ-012 mem_addr  output  32  registered byte address of 32-bit read; stable while mem_req high.
REQ-013 mem_ready  input  1  one-cycle pulse: mem_data valid, request complete.
REQ-014 mem_data  input  32  fetched word (controller handles unaligned halfword addresses).

Function
REQ-015 Entry = valid bit, tag pc[31:IC_INDEX_WIDTH+1], 32-bit data; index pc[IC_INDEX_WIDTH:1].
REQ-016 States: IDLE, WAIT, DISCARD, RESP.
REQ-017 ic_hit = fetch_enable_in AND state IDLE AND valid[index] AND tag match; ic_instr = entry data on hit, zero latency.
REQ-018 IDLE, fetch_enable_in, no hit, flush_in low: next cycle state WAIT, mem_req=1, mem_addr=pc_in with bit 0 cleared... bit 0 forced 0.
REQ-019 WAIT: mem_req held high, mem_addr unchanged until mem_ready.
REQ-020 WAIT, mem_ready, flush_in low: write entry (valid=1, tag, mem_data), latch mem_data into fill register, mem_req=0, state RESP.
REQ-021 RESP (exactly one cycle): ic_miss_ready=1, ic_instr=fill register, ic_hit=0; next state IDLE.
REQ-022 WAIT, flush_in high without mem_ready: state DISCARD, mem_req stays high (memory transaction not cancellable).
REQ-023 WAIT, flush_in and mem_ready same cycle: entry written, no RESP, state IDLE.
REQ-024 DISCARD, mem_ready: entry written (data still correct), mem_req=0, no ic_miss_ready, state IDLE.
REQ-025 flush_in in RESP: ic_miss_ready still pulses (fetcher ignores it); state IDLE next.
REQ-026 flush_in in IDLE: no miss started that cycle; ic_hit unaffected combinationally.
REQ-027 ic_instr is zero when neither hit nor RESP.
REQ-028 Fill and lookup of same index never conflict: lookups only in IDLE, writes only leaving WAIT/DISCARD.

Reset
REQ-029 On rst_in: all valid bits 0, state IDLE, mem_req 0, mem_addr 0, ic_miss_ready 0, fill register 0; takes effect immediately, aborting any in-flight miss with no fill.

Configuration
REQ-030 Macro ICACHE_BYPASS_EN: defined -> no storage, ic_hit constant 0, every fetch misses via WAIT/RESP, no entry writes; undefined -> cache as REQ-015..REQ-028.

Verification
REQ-031 Cold fetch pc=0x100, mem_ready 3 cycles later, mem_data=0x00A00093 -> mem_addr=0x100, one-cycle ic_miss_ready, ic_instr=0x00A00093, state IDLE.
REQ-032 Refetch pc=0x100 -> ic_hit=1 same cycle, ic_instr=0x00A00093, mem_req stays 0.
REQ-033 pc=0x102 then pc=0x102+2^(IC_INDEX_WIDTH+1)=0x182 (same index, other tag) -> second fetch misses, entry replaced, re-fetch 0x102 misses.
REQ-034 Miss pc=0x200, flush_in in WAIT, mem_ready later with 0x12345678 -> no ic_miss_ready; subsequent fetch 0x200 hits with 0x12345678.
REQ-035 rst_in asserted mid-WAIT -> mem_req 0 immediately, fetch of same pc afterwards misses.
REQ-036 rdy_in low for 5 cycles in WAIT with mem_ready absent -> state, mem_req, mem_addr unchanged; completes normally once rdy_in high.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signal bundle for icache_responder.
// The slave modport is the responder; the master modport is the fetcher/memory side.
interface icache_responder_if;
  logic        rdy_in;
  logic        flush_in;
  logic        fetch_enable_in;
  logic [31:0] pc_in;
  logic        ic_hit;
  logic        ic_miss_ready;
  logic [31:0] ic_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  rdy_in, flush_in, fetch_enable_in, pc_in, mem_ready, mem_data,
    output ic_hit, ic_miss_ready, ic_instr, mem_req, mem_addr
  );

  modport master (
    output rdy_in, flush_in, fetch_enable_in, pc_in, mem_ready, mem_data,
    input  ic_hit, ic_miss_ready, ic_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, halfword-indexed instruction cache responder with a single outstanding miss.
// Define ICACHE_BYPASS_EN to drop the storage: every fetch then misses through WAIT/RESP.
module icache_responder #(
  parameter int IC_INDEX_WIDTH = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  icache_responder_if.slave  bus
);

  localparam int ENTRIES = 1 << IC_INDEX_WIDTH;
  localparam int TAG_W   = 31 - IC_INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        miss_ready_q, miss_ready_d;
  logic [31:0] fill_q, fill_d;
  logic        hit_s;
  logic [31:0] hit_data_s;

`ifdef ICACHE_BYPASS_EN
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'h0000_0000;
`else
  logic [ENTRIES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q [ENTRIES];
  logic [31:0]               data_q [ENTRIES];
  logic [IC_INDEX_WIDTH-1:0] lookup_idx_s, fill_idx_s;
  logic [TAG_W-1:0]          lookup_tag_s, fill_tag_s;
  logic                      fill_write_s;

  assign lookup_idx_s = bus.pc_in[IC_INDEX_WIDTH:1];
  assign lookup_tag_s = bus.pc_in[31:IC_INDEX_WIDTH+1];
  // The in-flight address lives in mem_addr_q, so it also names the entry to fill.
  assign fill_idx_s   = mem_addr_q[IC_INDEX_WIDTH:1];
  assign fill_tag_s   = mem_addr_q[31:IC_INDEX_WIDTH+1];
  assign fill_write_s = bus.rdy_in && bus.mem_ready &&
                        ((state_q == ST_WAIT) || (state_q == ST_DISCARD));

  assign hit_s      = bus.fetch_enable_in && (state_q == ST_IDLE) &&
                      valid_q[lookup_idx_s] && (tag_q[lookup_idx_s] == lookup_tag_s);
  assign hit_data_s = data_q[lookup_idx_s];

  // Next valid vector: a completed fill sets its entry.
  always_comb begin
    valid_d = valid_q;
    if (fill_write_s) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits, cleared by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk_in) begin
    if (fill_write_s) begin
      tag_q[fill_idx_s]  <= fill_tag_s;
      data_q[fill_idx_s] <= bus.mem_data;
    end
  end
`endif

  // Miss FSM next state; rdy_in low holds every register.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    miss_ready_d = 1'b0;
    fill_d       = fill_q;
    if (bus.rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.fetch_enable_in && !hit_s && !bus.flush_in) begin
            state_d    = ST_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.pc_in[31:1], 1'b0};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            mem_req_d = 1'b0;
            if (bus.flush_in) begin
              state_d = ST_IDLE;
            end else begin
              state_d      = ST_RESP;
              fill_d       = bus.mem_data;
              miss_ready_d = 1'b1;
            end
          end else if (bus.flush_in) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DISCARD: begin
          if (bus.mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      miss_ready_d = miss_ready_q;
    end
  end

  // FSM and registered outputs; reset aborts any in-flight miss.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      miss_ready_q <= 1'b0;
      fill_q       <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      miss_ready_q <= miss_ready_d;
      fill_q       <= fill_d;
    end
  end

  // Instruction mux: hit data, else the fill word during RESP, else zero.
  always_comb begin
    if (hit_s) begin
      bus.ic_instr = hit_data_s;
    end else if (state_q == ST_RESP) begin
      bus.ic_instr = fill_q;
    end else begin
      bus.ic_instr = 32'h0000_0000;
    end
  end

  assign bus.ic_hit        = hit_s;
  assign bus.ic_miss_ready = miss_ready_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized fetches
// scored against a table-level cache model (index/tag computed arithmetically from pc).
module tb_icache_responder;

  localparam int IW      = 6;
  localparam int ENTRIES = 1 << IW;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  bit          model_valid [ENTRIES];
  logic [31:0] model_tag   [ENTRIES];
  logic [31:0] model_data  [ENTRIES];

  icache_responder_if bus ();

  icache_responder #(.IC_INDEX_WIDTH(IW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int model_idx(input logic [31:0] pc);
    return int'((pc / 32'd2) % ENTRIES);
  endfunction

  function automatic logic [31:0] model_tagof(input logic [31:0] pc);
    return pc / (32'd2 * ENTRIES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
`ifdef ICACHE_BYPASS_EN
    return 1'b0;
`else
    return model_valid[model_idx(pc)] && (model_tag[model_idx(pc)] == model_tagof(pc));
`endif
  endfunction

  function automatic void model_fill(input logic [31:0] pc, input logic [31:0] data);
`ifndef ICACHE_BYPASS_EN
    model_valid[model_idx(pc)] = 1'b1;
    model_tag[model_idx(pc)]   = model_tagof(pc);
    model_data[model_idx(pc)]  = data;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) model_valid[i] = 1'b0;
  endfunction

  // One fetch: hit check, or a full miss with lat wait cycles before mem_ready.
  // flush_cyc in [0, lat] flushes on that wait cycle (lat means together with mem_ready).
  task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] data,
                       input int flush_cyc, input int stall, input bit flush_resp);
    bit          exp_hit;
    logic [31:0] exp_addr;
    exp_hit  = model_hit(pc);
    exp_addr = pc & 32'hFFFF_FFFE;
    bus.fetch_enable_in = 1'b1;
    bus.pc_in           = pc;
    bus.flush_in        = 1'b0;
    #1;
    check_eq("lookup_hit", bus.ic_hit, exp_hit);
    check_eq("lookup_instr", bus.ic_instr, exp_hit ? model_data[model_idx(pc)] : 32'h0);
    @(posedge clk); #1;
    bus.fetch_enable_in = 1'b0;
    if (exp_hit) begin
      check_eq("hit_no_req", bus.mem_req, 32'h0);
      return;
    end
    check_eq("miss_req", bus.mem_req, 32'h1);
    check_eq("miss_addr", bus.mem_addr, exp_addr);
    for (int s = 0; s < stall; s++) begin
      bus.rdy_in    = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("stall_req", bus.mem_req, 32'h1);
      check_eq("stall_addr", bus.mem_addr, exp_addr);
      check_eq("stall_mrdy", bus.ic_miss_ready, 32'h0);
    end
    bus.rdy_in = 1'b1;
    for (int w = 0; w <= lat; w++) begin
      bus.mem_ready = (w == lat);
      bus.mem_data  = (w == lat) ? data : $urandom;
      bus.flush_in  = (w == flush_cyc);
      #1;
      check_eq("wait_req", bus.mem_req, 32'h1);
      check_eq("wait_addr", bus.mem_addr, exp_addr);
      check_eq("wait_instr", bus.ic_instr, 32'h0);
      check_eq("wait_mrdy", bus.ic_miss_ready, 32'h0);
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      bus.flush_in  = 1'b0;
    end
    model_fill(pc, data);
    check_eq("done_req", bus.mem_req, 32'h0);
    if (flush_cyc >= 0 && flush_cyc <= lat) begin
      check_eq("discard_mrdy", bus.ic_miss_ready, 32'h0);
      check_eq("discard_instr", bus.ic_instr, 32'h0);
    end else begin
      bus.flush_in        = flush_resp;
      bus.fetch_enable_in = 1'b1;
      #1;
      check_eq("resp_mrdy", bus.ic_miss_ready, 32'h1);
      check_eq("resp_instr", bus.ic_instr, data);
      check_eq("resp_nohit", bus.ic_hit, 32'h0);
      @(posedge clk); #1;
      bus.fetch_enable_in = 1'b0;
      bus.flush_in        = 1'b0;
      check_eq("resp_pulse_end", bus.ic_miss_ready, 32'h0);
      check_eq("resp_no_req", bus.mem_req, 32'h0);
    end
  endtask

  // Fetch with flush asserted in IDLE: lookup unaffected, no miss launched.
  task automatic idle_flush_fetch(input logic [31:0] pc);
    bus.fetch_enable_in = 1'b1;
    bus.flush_in        = 1'b1;
    bus.pc_in           = pc;
    #1;
    check_eq("iflush_hit", bus.ic_hit, model_hit(pc));
    @(posedge clk); #1;
    bus.fetch_enable_in = 1'b0;
    bus.flush_in        = 1'b0;
    check_eq("iflush_no_req", bus.mem_req, 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    int          rlat;
    int          rfl;
    n_total = 0;
    n_pass  = 0;
    model_reset();
    rst                 = 1'b1;
    bus.rdy_in          = 1'b1;
    bus.flush_in        = 1'b0;
    bus.fetch_enable_in = 1'b0;
    bus.pc_in           = 32'h0;
    bus.mem_ready       = 1'b0;
    bus.mem_data        = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", bus.mem_req, 32'h0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mrdy", bus.ic_miss_ready, 32'h0);
    check_eq("rst_instr", bus.ic_instr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then hit on refetch.
    fetch(32'h100, 3, 32'h00A0_0093, -1, 0, 1'b0);
    fetch(32'h100, 0, 32'h0, -1, 0, 1'b0);
    // Same index, different tag: replacement.
    fetch(32'h102, 1, 32'h1111_0102, -1, 0, 1'b0);
    fetch(32'h182, 2, 32'h2222_0182, -1, 0, 1'b0);
    fetch(32'h102, 0, 32'h3333_0102, -1, 0, 1'b1);
    fetch(32'h182, 0, 32'h0, -1, 0, 1'b0);
    // Flush during WAIT, fill still lands.
    fetch(32'h200, 3, 32'h1234_5678, 1, 0, 1'b0);
    fetch(32'h200, 0, 32'h0, -1, 0, 1'b0);
    // Flush together with mem_ready.
    fetch(32'h204, 2, 32'hCAFE_0204, 2, 0, 1'b0);
    fetch(32'h204, 0, 32'h0, -1, 0, 1'b0);
    // Flush in IDLE on a hit and on a miss.
    idle_flush_fetch(32'h200);
    idle_flush_fetch(32'h400);
    // rdy_in low for 5 cycles in WAIT.
    fetch(32'h40A, 2, 32'h5A5A_A5A5, -1, 5, 1'b0);
    fetch(32'h40B, 0, 32'h0, -1, 0, 1'b0);

    // Reset mid-WAIT aborts the miss and clears all entries.
    bus.fetch_enable_in = 1'b1;
    bus.pc_in           = 32'h300;
    @(posedge clk); #1;
    bus.fetch_enable_in = 1'b0;
    check_eq("prerst_req", bus.mem_req, 32'h1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_eq("midrst_req", bus.mem_req, 32'h0);
    check_eq("midrst_addr", bus.mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    fetch(32'h300, 1, 32'h0300_0300, -1, 0, 1'b0);
    fetch(32'h200, 1, 32'h0200_0200, -1, 0, 1'b0);
    fetch(32'h300, 0, 32'h0, -1, 0, 1'b0);

    // Randomized fetches over a small address pool to force hits and conflicts.
    for (int it = 0; it < 60; it++) begin
      rpc  = 32'h1000 | ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 1)
             | 32'($urandom_range(0, 1));
      rlat = $urandom_range(0, 4);
      rfl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rlat) : -1;
      fetch(rpc, rlat, $urandom, rfl, ($urandom_range(0, 5) == 0) ? 2 : 0,
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idle_flush_fetch(rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
